// File: rtl/pipe_stage_regs_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_regs_pkg
//   Shared Y86-64 encodings and pipeline-bundle layouts for the stage register
//   bank. This package plays the role that define.v plays in the original
//   codebase. It provides:
//     - status and instruction codes
//     - the "no register" id
//     - the field layout of each stage bundle
//     - the NOP image that a bubble loads
//     - the saturating-add helper shared by the performance counters
//
//   Bundle layout: the named fields are packed MSB-first, in the listed order,
//   starting at the top bit of the bundle. When a bundle parameter is wider than
//   its named fields, the leftover low-order bits are reserved. Reserved bits
//   pass through untouched and are zero in the NOP image. As a result, stat
//   always occupies the top three bits of every bundle.
// -----------------------------------------------------------------------------
package pipe_stage_regs_pkg;

    // Y86-64 status codes; SBUB marks a slot that holds an inserted bubble.
    typedef enum logic [2:0] {
        SBUB = 3'd0,
        SAOK = 3'd1,
        SHLT = 3'd2,
        SADR = 3'd3,
        SINS = 3'd4
    } stat_e;

    // Y86-64 instruction codes.
    typedef enum logic [3:0] {
        IHALT   = 4'h0,
        INOP    = 4'h1,
        IRRMOVQ = 4'h2,
        IIRMOVQ = 4'h3,
        IRMMOVQ = 4'h4,
        IMRMOVQ = 4'h5,
        IOPQ    = 4'h6,
        IJXX    = 4'h7,
        ICALL   = 4'h8,
        IRET    = 4'h9,
        IPUSHQ  = 4'hA,
        IPOPQ   = 4'hB
    } icode_e;

    localparam logic [3:0] RNONE = 4'hF;

    // Named-field layouts of the stage bundles. Each struct sits at the MSB end
    // of its bundle.
    typedef struct packed {
        stat_e       stat;
        icode_e      icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } d_core_t;

    typedef struct packed {
        stat_e       stat;
        icode_e      icode;
        logic [3:0]  ifun;
        logic [63:0] valc;
        logic [63:0] vala;
        logic [63:0] valb;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [3:0]  srca;
        logic [3:0]  srcb;
    } e_core_t;

    typedef struct packed {
        stat_e       stat;
        icode_e      icode;
        logic        cnd;
        logic [63:0] vale;
        logic [63:0] vala;
        logic [3:0]  dste;
        logic [3:0]  dstm;
    } m_core_t;

    typedef struct packed {
        stat_e       stat;
        icode_e      icode;
        logic [63:0] vale;
        logic [63:0] valm;
        logic [3:0]  dste;
        logic [3:0]  dstm;
    } w_core_t;

    localparam int D_CORE_W = $bits(d_core_t);
    localparam int E_CORE_W = $bits(e_core_t);
    localparam int M_CORE_W = $bits(m_core_t);
    localparam int W_CORE_W = $bits(w_core_t);
    localparam int STAT_W   = $bits(stat_e);

    // NOP images of the named fields. Data fields are zero and every register
    // id is RNONE, so a bubble can never create a false forwarding match
    // downstream.
    localparam d_core_t D_NOP = '{
        stat: SBUB, icode: INOP, ifun: 4'h0,
        ra: RNONE, rb: RNONE, valc: 64'd0, valp: 64'd0
    };

    localparam e_core_t E_NOP = '{
        stat: SBUB, icode: INOP, ifun: 4'h0,
        valc: 64'd0, vala: 64'd0, valb: 64'd0,
        dste: RNONE, dstm: RNONE, srca: RNONE, srcb: RNONE
    };

    localparam m_core_t M_NOP = '{
        stat: SBUB, icode: INOP, cnd: 1'b0,
        vale: 64'd0, vala: 64'd0, dste: RNONE, dstm: RNONE
    };

    localparam w_core_t W_NOP = '{
        stat: SBUB, icode: INOP,
        vale: 64'd0, valm: 64'd0, dste: RNONE, dstm: RNONE
    };

    // Adds a small increment to a 32-bit event counter and sticks at all-ones
    // instead of wrapping. The wrap would make long-run statistics silently
    // wrong.
    function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                            input logic [1:0]  inc);
        logic [32:0] sum;
        sum = {1'b0, acc} + {31'd0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage : pipe_stage_regs_pkg

// File: rtl/pipe_stage_regs_pipe_reg.sv
// -----------------------------------------------------------------------------
// pipe_reg
//   One pipeline register with hold and bubble controls. On each rising edge,
//   the register does one of three things, in priority order:
//     - stall_i asserted: keep the current contents
//     - bubble_i asserted: load NOP_VAL
//     - otherwise: capture d_i
//   Stall has priority over bubble. An asynchronous reset loads NOP_VAL.
//
// Parameters
//   W        register width
//   NOP_VAL  value loaded on reset and on bubble
// Ports
//   clk_i     in  1  clock, rising edge
//   rst_n_i   in  1  async active-low reset
//   stall_i   in  1  hold contents
//   bubble_i  in  1  load NOP_VAL
//   d_i       in  W  next contents from the upstream stage
//   q_o       out W  registered contents
// -----------------------------------------------------------------------------
module pipe_reg #(
    parameter int         W       = 1,
    parameter logic [W-1:0] NOP_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         stall_i,
    input  logic         bubble_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // NOTE: sequential state uses non-blocking (<=) so that every register in
    // the bank samples its input before any of them updates, whatever order
    // the simulator evaluates the blocks in.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_o <= NOP_VAL;
        end else if (!stall_i) begin
            q_o <= bubble_i ? NOP_VAL : d_i;
        end
    end

endmodule : pipe_reg

// File: rtl/pipe_stage_regs.sv
// -----------------------------------------------------------------------------
// pipe_stage_regs
//   The bank of Y86-64 pipeline registers F, D, E, M and W. This block:
//     - applies the hazard unit's stall and bubble controls on every rising
//       edge
//     - keeps a sticky flag for the illegal D stall+bubble combination
//     - counts cycles, retired instructions and inserted bubbles
//
//   Stall means the register holds its contents. Bubble means the register
//   loads its NOP image. The stage bundles are opaque and pass through
//   bit-exact. The only field this block reads is the W status, which it needs
//   to count retirements.
//
//   Not every control exists for every register:
//     - F has no bubble.
//     - E and M have no stall.
//     - W has no bubble. W_stall_i is the halt/exception freeze, and it also
//       stops the cycle and retire counters.
//
// Parameters
//   RESET_PC  F_predPC value after reset
//   WD/WE/WM/WW  widths of the D/E/M/W bundles (at least the named-field width)
// Ports
//   clk_i, rst_n_i          clock (rising edge) and async active-low reset
//   f_predPC_i  [63:0]      next predicted PC from fetch       -> F
//   f_bundle_i  [WD-1:0]    fetch outputs                      -> D
//   d_bundle_i  [WE-1:0]    decode outputs                     -> E
//   e_bundle_i  [WM-1:0]    execute outputs                    -> M
//   m_bundle_i  [WW-1:0]    memory outputs                     -> W
//   F_stall_i, D_stall_i, D_bubble_i, E_bubble_i, M_bubble_i, W_stall_i
//                           stage controls from the hazard unit
//   F_predPC_o, D_bundle_o, E_bundle_o, M_bundle_o, W_bundle_o
//                           register contents
//   ctrl_err_o              sticky: D stall and D bubble were seen together
//   perf_cycles_o  [31:0]   edges while not halted
//   perf_retired_o [31:0]   instructions that left W with status AOK
//   perf_bubbles_o [31:0]   bubbles actually inserted into D, E and M
// -----------------------------------------------------------------------------
module pipe_stage_regs
    import pipe_stage_regs_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          WD       = 157,
    parameter int          WE       = 223,
    parameter int          WM       = 148,
    parameter int          WW       = 147
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [63:0]   f_predPC_i,
    input  logic [WD-1:0] f_bundle_i,
    input  logic [WE-1:0] d_bundle_i,
    input  logic [WM-1:0] e_bundle_i,
    input  logic [WW-1:0] m_bundle_i,
    input  logic          F_stall_i,
    input  logic          D_stall_i,
    input  logic          D_bubble_i,
    input  logic          E_bubble_i,
    input  logic          M_bubble_i,
    input  logic          W_stall_i,
    output logic [63:0]   F_predPC_o,
    output logic [WD-1:0] D_bundle_o,
    output logic [WE-1:0] E_bundle_o,
    output logic [WM-1:0] M_bundle_o,
    output logic [WW-1:0] W_bundle_o,
    output logic          ctrl_err_o,
    output logic [31:0]   perf_cycles_o,
    output logic [31:0]   perf_retired_o,
    output logic [31:0]   perf_bubbles_o
);

    // Full-width NOP images. Each one is the named-field image moved to the
    // MSB end, with zeros in the reserved low bits.
    localparam logic [WD-1:0] D_NOP_IMG = WD'(D_NOP) << (WD - D_CORE_W);
    localparam logic [WE-1:0] E_NOP_IMG = WE'(E_NOP) << (WE - E_CORE_W);
    localparam logic [WM-1:0] M_NOP_IMG = WM'(M_NOP) << (WM - M_CORE_W);
    localparam logic [WW-1:0] W_NOP_IMG = WW'(W_NOP) << (WW - W_CORE_W);

    // ---------------------------------------------------------------- registers
    pipe_reg #(.W(64), .NOP_VAL(RESET_PC)) u_f_reg (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .stall_i  (F_stall_i),
        .bubble_i (1'b0),
        .d_i      (f_predPC_i),
        .q_o      (F_predPC_o)
    );

    pipe_reg #(.W(WD), .NOP_VAL(D_NOP_IMG)) u_d_reg (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .stall_i  (D_stall_i),
        .bubble_i (D_bubble_i),
        .d_i      (f_bundle_i),
        .q_o      (D_bundle_o)
    );

    pipe_reg #(.W(WE), .NOP_VAL(E_NOP_IMG)) u_e_reg (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .stall_i  (1'b0),
        .bubble_i (E_bubble_i),
        .d_i      (d_bundle_i),
        .q_o      (E_bundle_o)
    );

    pipe_reg #(.W(WM), .NOP_VAL(M_NOP_IMG)) u_m_reg (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .stall_i  (1'b0),
        .bubble_i (M_bubble_i),
        .d_i      (e_bundle_i),
        .q_o      (M_bundle_o)
    );

    pipe_reg #(.W(WW), .NOP_VAL(W_NOP_IMG)) u_w_reg (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .stall_i  (W_stall_i),
        .bubble_i (1'b0),
        .d_i      (m_bundle_i),
        .q_o      (W_bundle_o)
    );

    // ------------------------------------------------------- event decoding
    logic        halted;
    logic        retire;
    logic        d_bubble_applied;
    logic        ctrl_conflict;
    logic [1:0]  bubble_inc;
    stat_e       w_stat;

    // NOTE: every signal driven from always_comb is given a value on every path
    // (here: unconditionally); a path that leaves one unassigned infers a latch.
    always_comb begin
        w_stat           = stat_e'(W_bundle_o[WW-1 -: STAT_W]);
        halted           = W_stall_i;
        // The W contents leave the pipe on this edge unless W is frozen.
        retire           = (w_stat == SAOK) && !halted;
        // A stalled D keeps its instruction, so a simultaneous bubble request
        // inserts nothing and must not be counted.
        d_bubble_applied = D_bubble_i && !D_stall_i;
        ctrl_conflict    = D_stall_i && D_bubble_i;
        bubble_inc       = {1'b0, d_bubble_applied} + {1'b0, E_bubble_i}
                         + {1'b0, M_bubble_i};
    end

    // ------------------------------------------------ counters and error flag
    logic [31:0] cycles_q;
    logic [31:0] retired_q;
    logic [31:0] bubbles_q;
    logic        ctrl_err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cycles_q   <= 32'd0;
            retired_q  <= 32'd0;
            bubbles_q  <= 32'd0;
            ctrl_err_q <= 1'b0;
        end else begin
            cycles_q   <= sat_add(cycles_q,  {1'b0, !halted});
            retired_q  <= sat_add(retired_q, {1'b0, retire});
            bubbles_q  <= sat_add(bubbles_q, bubble_inc);
            // Sticky until reset so that software can find the violation after
            // the fact.
            ctrl_err_q <= ctrl_err_q | ctrl_conflict;
        end
    end

    assign perf_cycles_o  = cycles_q;
    assign perf_retired_o = retired_q;
    assign perf_bubbles_o = bubbles_q;
    assign ctrl_err_o     = ctrl_err_q;

endmodule : pipe_stage_regs

// File: tb/tb_pipe_stage_regs.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_regs
//   Self-checking bench for pipe_stage_regs. It runs directed scenarios for:
//     - reset
//     - flow
//     - load-use
//     - mispredict
//     - D stall/bubble conflict
//     - halt and counter saturation
//   It then runs randomized traffic with a mid-run reset. Every output is
//   compared on the falling edge against a behavioural model of the stage
//   rules. The model uses its own constants for status codes and NOP images.
// -----------------------------------------------------------------------------
module tb_pipe_stage_regs;

    localparam int          WD  = 157;
    localparam int          WE  = 223;
    localparam int          WM  = 148;
    localparam int          WW  = 147;
    localparam logic [63:0] RPC = 64'h0000_0000_0000_1000;

    localparam logic [2:0] S_BUB    = 3'd0;
    localparam logic [2:0] S_AOK    = 3'd1;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam longint     CMAX     = 64'h0000_0000_FFFF_FFFF;

    // Bubble images: {stat,icode,...} at the MSB end, ids 4'hF, data 0, pad 0.
    localparam logic [WD-1:0] NOP_D = {S_BUB, I_NOP, 4'h0, 8'hFF, 128'd0, 10'd0};
    localparam logic [WE-1:0] NOP_E = {S_BUB, I_NOP, 4'h0, 192'd0, 16'hFFFF, 4'd0};
    localparam logic [WM-1:0] NOP_M = {S_BUB, I_NOP, 1'b0, 128'd0, 8'hFF, 4'd0};
    localparam logic [WW-1:0] NOP_W = {S_BUB, I_NOP, 128'd0, 8'hFF, 4'd0};

    logic          clk;
    logic          rst_n;
    logic [63:0]   f_pc;
    logic [WD-1:0] f_in;
    logic [WE-1:0] d_in;
    logic [WM-1:0] e_in;
    logic [WW-1:0] m_in;
    logic          f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall;
    logic [63:0]   f_out;
    logic [WD-1:0] d_out;
    logic [WE-1:0] e_out;
    logic [WM-1:0] m_out;
    logic [WW-1:0] w_out;
    logic          err_out;
    logic [31:0]   cyc_out, ret_out, bub_out;

    pipe_stage_regs #(
        .RESET_PC(RPC), .WD(WD), .WE(WE), .WM(WM), .WW(WW)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .f_predPC_i     (f_pc),
        .f_bundle_i     (f_in),
        .d_bundle_i     (d_in),
        .e_bundle_i     (e_in),
        .m_bundle_i     (m_in),
        .F_stall_i      (f_stall),
        .D_stall_i      (d_stall),
        .D_bubble_i     (d_bubble),
        .E_bubble_i     (e_bubble),
        .M_bubble_i     (m_bubble),
        .W_stall_i      (w_stall),
        .F_predPC_o     (f_out),
        .D_bundle_o     (d_out),
        .E_bundle_o     (e_out),
        .M_bundle_o     (m_out),
        .W_bundle_o     (w_out),
        .ctrl_err_o     (err_out),
        .perf_cycles_o  (cyc_out),
        .perf_retired_o (ret_out),
        .perf_bubbles_o (bub_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ----------------------------------------------------------- model state
    logic [63:0]   x_f;
    logic [WD-1:0] x_d;
    logic [WE-1:0] x_e;
    logic [WM-1:0] x_m;
    logic [WW-1:0] x_w;
    logic          x_err;
    longint        x_cyc, x_ret, x_bub;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic longint sat(input longint v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_reset();
        x_f = RPC; x_d = NOP_D; x_e = NOP_E; x_m = NOP_M; x_w = NOP_W;
        x_err = 1'b0; x_cyc = 0; x_ret = 0; x_bub = 0;
    endtask

    // One clock edge applied to the model, using the inputs currently driven.
    task automatic model_update();
        int added;
        if (!w_stall) x_cyc = sat(x_cyc + 1);
        if (!w_stall && x_w[WW-1 -: 3] == S_AOK) x_ret = sat(x_ret + 1);
        added = int'(d_bubble && !d_stall) + int'(e_bubble) + int'(m_bubble);
        x_bub = sat(x_bub + added);
        if (d_stall && d_bubble) x_err = 1'b1;
        if (!f_stall) x_f = f_pc;
        if (!d_stall) x_d = d_bubble ? NOP_D : f_in;
        x_e = e_bubble ? NOP_E : d_in;
        x_m = m_bubble ? NOP_M : e_in;
        if (!w_stall) x_w = m_in;
    endtask

    task automatic compare_all(input string where);
        check({where, ":F"},   256'(f_out),   256'(x_f));
        check({where, ":D"},   256'(d_out),   256'(x_d));
        check({where, ":E"},   256'(e_out),   256'(x_e));
        check({where, ":M"},   256'(m_out),   256'(x_m));
        check({where, ":W"},   256'(w_out),   256'(x_w));
        check({where, ":err"}, 256'(err_out), 256'(x_err));
        check({where, ":cyc"}, 256'(cyc_out), 256'(x_cyc));
        check({where, ":ret"}, 256'(ret_out), 256'(x_ret));
        check({where, ":bub"}, 256'(bub_out), 256'(x_bub));
    endtask

    // Called at a falling edge with the inputs already set up.
    task automatic tick(input string where);
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all(where);
    endtask

    task automatic clear_ctrl();
        f_stall = 0; d_stall = 0; d_bubble = 0;
        e_bubble = 0; m_bubble = 0; w_stall = 0;
    endtask

    task automatic rand_data();
        f_pc = 64'(rnd256());
        f_in = WD'(rnd256());
        d_in = WE'(rnd256());
        e_in = WM'(rnd256());
        m_in = WW'(rnd256());
        if ($urandom_range(0, 9) < 6) m_in[WW-1 -: 3] = S_AOK;
    endtask

    // Emulates the stage datapaths: each stage passes its own status and icode
    // along, taken from the model's view of the current register contents.
    task automatic forward_inputs();
        d_in = WE'(rnd256());
        e_in = WM'(rnd256());
        m_in = WW'(rnd256());
        d_in[WE-1 -: 7] = x_d[WD-1 -: 7];
        e_in[WM-1 -: 7] = x_e[WE-1 -: 7];
        m_in[WW-1 -: 7] = x_m[WM-1 -: 7];
    endtask

    initial begin
        logic [WD-1:0] saved_d;
        logic [WW-1:0] saved_w;
        logic [63:0]   saved_f;
        longint        saved_cyc, saved_ret;

        // ---------------------------------------------------------- reset
        rst_n = 1'b0;
        clear_ctrl();
        rand_data();
        repeat (3) @(negedge clk);
        model_reset();
        compare_all("reset");
        check("reset:D_stat",  256'(d_out[WD-1 -: 3]), 256'(S_BUB));
        check("reset:W_icode", 256'(w_out[WW-4 -: 4]), 256'(I_NOP));
        rst_n = 1'b1;

        // ----------------------------------------------------------- flow
        f_pc = 64'h40;
        f_in = WD'(rnd256());
        f_in[WD-1 -: 7] = {S_AOK, I_IRMOVQ};
        forward_inputs();
        tick("flow0");
        for (int i = 0; i < 4; i++) begin
            f_pc = f_pc + 64'd10;
            f_in = WD'(rnd256());
            f_in[WD-1 -: 7] = {S_BUB, I_NOP};
            forward_inputs();
            tick($sformatf("flow%0d", i + 1));
            if (i == 2) begin
                check("flow:W_stat",  256'(w_out[WW-1 -: 3]), 256'(S_AOK));
                check("flow:W_icode", 256'(w_out[WW-4 -: 4]), 256'(I_IRMOVQ));
            end
        end
        check("flow:retired", 256'(ret_out), 256'(1));

        // ------------------------------------------------------- load-use
        rand_data();
        saved_f = x_f; saved_d = x_d; saved_cyc = x_bub;
        f_stall = 1; d_stall = 1; e_bubble = 1;
        tick("loaduse");
        check("loaduse:F", 256'(f_out), 256'(saved_f));
        check("loaduse:D", 256'(d_out), 256'(saved_d));
        check("loaduse:E", 256'(e_out), 256'(NOP_E));
        check("loaduse:bub", 256'(bub_out), 256'(saved_cyc + 1));
        check("loaduse:err", 256'(err_out), 256'(0));
        clear_ctrl();

        // ----------------------------------------------------- mispredict
        rand_data();
        saved_cyc = x_bub;
        d_bubble = 1; e_bubble = 1;
        tick("mispred");
        check("mispred:D", 256'(d_out), 256'(NOP_D));
        check("mispred:E", 256'(e_out), 256'(NOP_E));
        check("mispred:bub", 256'(bub_out), 256'(saved_cyc + 2));
        clear_ctrl();

        // ------------------------------------------------------- conflict
        rand_data();
        saved_d = x_d;
        d_stall = 1; d_bubble = 1;
        tick("conflict");
        check("conflict:D", 256'(d_out), 256'(saved_d));
        check("conflict:err", 256'(err_out), 256'(1));
        clear_ctrl();
        for (int i = 0; i < 4; i++) begin
            rand_data();
            tick("conflict_after");
        end
        check("conflict:sticky", 256'(err_out), 256'(1));

        // ----------------------------------------------------------- halt
        rand_data();
        m_in[WW-1 -: 3] = S_AOK;
        tick("pre_halt");
        saved_w = x_w; saved_cyc = x_cyc; saved_ret = x_ret;
        w_stall = 1;
        for (int i = 0; i < 10; i++) begin
            rand_data();
            tick("halt");
        end
        check("halt:W", 256'(w_out), 256'(saved_w));
        check("halt:cyc", 256'(cyc_out), 256'(saved_cyc));
        check("halt:ret", 256'(ret_out), 256'(saved_ret));
        clear_ctrl();

        // ----------------------------------------------------- saturation
        rand_data();
        force dut.cycles_q = 32'hFFFF_FFFE;
        @(posedge clk);
        model_update();
        @(negedge clk);
        release dut.cycles_q;
        x_cyc = 64'h0000_0000_FFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            tick("sat");
        end
        check("sat:cyc", 256'(cyc_out), 256'(32'hFFFF_FFFF));

        // ------------------------------------------ random with mid reset
        for (int n = 0; n < 400; n++) begin
            rand_data();
            f_stall  = ($urandom_range(0, 5) == 0);
            d_stall  = ($urandom_range(0, 5) == 0);
            d_bubble = ($urandom_range(0, 5) == 0);
            e_bubble = ($urandom_range(0, 5) == 0);
            m_bubble = ($urandom_range(0, 5) == 0);
            w_stall  = ($urandom_range(0, 7) == 0);
            tick($sformatf("rnd%0d", n));
            if (n == 200) begin
                #2 rst_n = 1'b0;
                #1 model_reset();
                compare_all("mid_rst");
                @(negedge clk);
                compare_all("mid_rst_hold");
                rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pipe_stage_regs
